// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package mem_port_arbiter_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam int unsigned NR_REQ_MIN = 2;
   localparam int unsigned NR_REQ_MAX = 8;

   // Ceiling log2, never below 1 so index vectors always have a bit
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      int unsigned r;
      w = 1;
      r = 0;
      while (w < n) begin
         w = w << 1;
         r = r + 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bus bundle for the arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned NR_REQ = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   import mem_port_arbiter_pkg::*;

   localparam int unsigned GID_W = clog2(NR_REQ);

   logic [NR_REQ-1:0]        m_req_valid;
   logic [NR_REQ-1:0]        m_req_ready;
   logic [NR_REQ*ADDR_W-1:0] m_req_addr;
   logic [NR_REQ-1:0]        m_req_wen;
   logic [NR_REQ*DATA_W-1:0] m_req_wdata;
   logic [NR_REQ-1:0]        m_resp_valid;
   logic [NR_REQ-1:0]        m_resp_ready;
   logic [DATA_W-1:0]        m_resp_rdata;

   logic                     s_req_valid;
   logic                     s_req_ready;
   logic [ADDR_W-1:0]        s_req_addr;
   logic                     s_req_wen;
   logic [DATA_W-1:0]        s_req_wdata;
   logic                     s_resp_valid;
   logic                     s_resp_ready;
   logic [DATA_W-1:0]        s_resp_rdata;

   logic                     busy;
   logic [GID_W-1:0]         grant_id;

   // Arbiter view: serves the requesters, masters the memory port
   modport master (
      input  m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_resp_ready,
      output m_req_ready, m_resp_valid, m_resp_rdata,
      output s_req_valid, s_req_addr, s_req_wen, s_req_wdata, s_resp_ready,
      input  s_req_ready, s_resp_valid, s_resp_rdata,
      output busy, grant_id
   );

   // Environment view: requesters plus memory
   modport slave (
      output m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_resp_ready,
      input  m_req_ready, m_resp_valid, m_resp_rdata,
      input  s_req_valid, s_req_addr, s_req_wen, s_req_wdata, s_resp_ready,
      output s_req_ready, s_resp_valid, s_resp_rdata,
      input  busy, grant_id
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker (rr_pick): first set request after i_last.
module mem_port_arbiter_rr_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned NR_REQ = 2
) (
   input  logic [NR_REQ-1:0]         i_req,
   input  logic [clog2(NR_REQ)-1:0]  i_last,
   output logic                      o_any_c,
   output logic [clog2(NR_REQ)-1:0]  o_pick_c
);

   localparam int unsigned GID_W = clog2(NR_REQ);

   logic              w_found;
   int unsigned       w_idx;
   logic [GID_W-1:0]  w_pick;

   assign o_any_c  = |i_req;
   assign o_pick_c = w_pick;

   // Scan last+1, last+2, ... modulo NR_REQ and keep the first hit
   always_comb begin
      w_found = 1'b0;
      w_idx   = 0;
      w_pick  = '0;
      for (int unsigned k = 1; k <= NR_REQ; k++) begin
         w_idx = (32'(i_last) + k) % NR_REQ;
         if (!w_found && i_req[GID_W'(w_idx)]) begin
            w_found = 1'b1;
            w_pick  = GID_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NR_REQ requesters (2..8),
// one request/response transaction in flight at a time.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned NR_REQ = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.master bus
);

   localparam int unsigned GID_W = clog2(NR_REQ);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [GID_W-1:0]   r_gid;
   logic [GID_W-1:0]   w_gid_nxt;
   logic [GID_W-1:0]   r_last;
   logic [GID_W-1:0]   w_last_nxt;

   logic [NR_REQ-1:0]  w_pick_req;
   logic               w_any;
   logic [GID_W-1:0]   w_pick;

   logic               w_s_req_valid;
   logic [NR_REQ-1:0]  w_m_req_ready;
   logic [NR_REQ-1:0]  w_m_resp_valid;
   logic               w_s_resp_ready;

   logic [NR_REQ-1:0]  w_sel;
   logic [ADDR_W-1:0]  w_addr;
   logic               w_wen;
   logic [DATA_W-1:0]  w_wdata;

   // Picker only sees the request vector while idle
   assign w_pick_req = (r_state == ST_IDLE) ? bus.m_req_valid : '0;

   mem_port_arbiter_rr_pick #(
      .NR_REQ (NR_REQ)
   ) u_rr_pick (
      .i_req    (w_pick_req),
      .i_last   (r_last),
      .o_any_c  (w_any),
      .o_pick_c (w_pick)
   );

   // State, grant and last-served registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_gid   <= '0;
         r_last  <= GID_W'(NR_REQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_gid   <= w_gid_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Next state and handshake steering toward the granted requester
   always_comb begin
      w_state_nxt    = r_state;
      w_gid_nxt      = r_gid;
      w_last_nxt     = r_last;
      w_s_req_valid  = 1'b0;
      w_m_req_ready  = '0;
      w_m_resp_valid = '0;
      w_s_resp_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_gid_nxt   = w_pick;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            w_s_req_valid        = bus.m_req_valid[r_gid];
            w_m_req_ready[r_gid] = bus.s_req_ready;
            if (w_s_req_valid && bus.s_req_ready) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            w_m_resp_valid[r_gid] = bus.s_resp_valid;
            w_s_resp_ready        = bus.m_resp_ready[r_gid];
            if (bus.s_resp_valid && w_s_resp_ready) begin
               w_last_nxt  = r_gid;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // One-hot AND-OR payload select; zero outside GRANT
   always_comb begin
      w_sel   = (r_state == ST_GRANT) ? (NR_REQ'(1) << r_gid) : '0;
      w_addr  = '0;
      w_wen   = 1'b0;
      w_wdata = '0;
      for (int unsigned n = 0; n < NR_REQ; n++) begin
         w_addr  = w_addr  | (bus.m_req_addr[ADDR_W*n +: ADDR_W]  & {ADDR_W{w_sel[n]}});
         w_wen   = w_wen   | (bus.m_req_wen[n] & w_sel[n]);
         w_wdata = w_wdata | (bus.m_req_wdata[DATA_W*n +: DATA_W] & {DATA_W{w_sel[n]}});
      end
   end

   assign bus.s_req_valid  = w_s_req_valid;
   assign bus.s_req_addr   = w_addr;
   assign bus.s_req_wen    = w_wen;
   assign bus.s_req_wdata  = w_wdata;
   assign bus.s_resp_ready = w_s_resp_ready;
   assign bus.m_req_ready  = w_m_req_ready;
   assign bus.m_resp_valid = w_m_resp_valid;
   assign bus.m_resp_rdata = bus.s_resp_rdata;
   assign bus.busy         = (r_state != ST_IDLE);
   assign bus.grant_id     = r_gid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a 2-requester and a 3-requester instance.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.NR_REQ(2), .ADDR_W(AW), .DATA_W(DW)) bus2 ();
   mem_port_arbiter_if #(.NR_REQ(3), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

   mem_port_arbiter #(.NR_REQ(2), .ADDR_W(AW), .DATA_W(DW)) dut2 (
      .clk (clk), .rst_n (rst_n), .bus (bus2)
   );
   mem_port_arbiter #(.NR_REQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
      .clk (clk), .rst_n (rst_n), .bus (bus3)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_gnt2 = 0;
   int n_gnt3 = 0;
   logic       hold2;
   logic [1:0] acc2;

   int          exp_g2[$];
   int          exp_g3[$];
   int          exp_rid[$];
   logic [31:0] exp_rd[$];

   // Memory read data is a fixed function of the accepted address
   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return {16'h0000, a[15:0]} ^ 32'h0000_1234;
   endfunction

   logic [AW-1:0] lat2;
   always @(posedge clk) if (bus2.s_req_valid && bus2.s_req_ready) lat2 <= bus2.s_req_addr;
   assign bus2.s_resp_rdata = rd_fn(lat2);
   assign bus3.s_resp_rdata = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sample phase: exclusivity checks and scoreboard pops at the falling edge
   task automatic smp();
      logic [1:0] m2;
      logic [2:0] m3;
      @(negedge clk);
      acc2 = '0;
      if (rst_n) begin
         m2 = 2'(1) << bus2.grant_id;
         m3 = 3'(1) << bus3.grant_id;
         chk("rdy_excl2", 32'(bus2.m_req_ready & ~m2), 0);
         chk("rvld_excl2", 32'(bus2.m_resp_valid & ~m2), 0);
         chk("rdy_excl3", 32'(bus3.m_req_ready & ~m3), 0);
         if (bus2.s_req_valid && bus2.s_req_ready) begin
            n_gnt2++;
            chk("gnt2_pend", 32'(exp_g2.size() != 0), 1);
            if (exp_g2.size() != 0) chk("gnt2_id", 32'(bus2.grant_id), exp_g2.pop_front());
         end
         if (bus3.s_req_valid && bus3.s_req_ready) begin
            n_gnt3++;
            chk("gnt3_pend", 32'(exp_g3.size() != 0), 1);
            if (exp_g3.size() != 0) chk("gnt3_id", 32'(bus3.grant_id), exp_g3.pop_front());
         end
         for (int i = 0; i < 2; i++) begin
            if (bus2.m_resp_valid[i] && bus2.m_resp_ready[i]) begin
               chk("rsp_pend", 32'(exp_rid.size() != 0), 1);
               if (exp_rid.size() != 0) begin
                  chk("rsp_id", 32'(i), exp_rid.pop_front());
                  chk("rsp_data", bus2.m_resp_rdata, exp_rd.pop_front());
               end
            end
         end
         acc2 = bus2.m_req_valid & bus2.m_req_ready;
      end
   endtask

   // Advance phase: clock edge, then requesters drop accepted requests
   task automatic adv();
      @(posedge clk);
      #1;
      if (!hold2) bus2.m_req_valid = bus2.m_req_valid & ~acc2;
   endtask

   task automatic push_rsp(input int id, input logic [31:0] addr);
      exp_rid.push_back(id);
      exp_rd.push_back(rd_fn(addr));
   endtask

   task automatic set_addr2(input int slot, input logic [31:0] a);
      bus2.m_req_addr[32*slot +: 32] = a;
   endtask

   task automatic wait_idle(input int budget);
      int  k;
      logic idle;
      k = 0;
      idle = 1'b0;
      while (!idle && k < budget) begin
         smp();
         idle = !bus2.busy && !bus3.busy && exp_g2.size() == 0 &&
                exp_g3.size() == 0 && exp_rid.size() == 0;
         adv();
         k++;
      end
      chk("idle_timeout", 32'(idle), 1);
   endtask

   task automatic until_gnt2(input int target, input int budget);
      int k;
      k = 0;
      while (n_gnt2 < target && k < budget) begin smp(); adv(); k++; end
      chk("gnt2_count", 32'(n_gnt2), 32'(target));
   endtask

   task automatic until_gnt3(input int target, input int budget);
      int k;
      k = 0;
      while (n_gnt3 < target && k < budget) begin smp(); adv(); k++; end
      chk("gnt3_count", 32'(n_gnt3), 32'(target));
   endtask

   task automatic chk_rst();
      chk("rst_sreqv2", 32'(bus2.s_req_valid), 0);
      chk("rst_srspr2", 32'(bus2.s_resp_ready), 0);
      chk("rst_mreqr2", 32'(bus2.m_req_ready), 0);
      chk("rst_mrspv2", 32'(bus2.m_resp_valid), 0);
      chk("rst_busy2", 32'(bus2.busy), 0);
      chk("rst_gid2", 32'(bus2.grant_id), 0);
      chk("rst_saddr2", bus2.s_req_addr, 0);
      chk("rst_busy3", 32'(bus3.busy), 0);
      chk("rst_sreqv3", 32'(bus3.s_req_valid), 0);
   endtask

   task automatic clr_inputs();
      bus2.m_req_valid  = '0; bus2.m_req_wen = '0; bus2.m_resp_ready = '0;
      bus2.s_req_ready  = 1'b0; bus2.s_resp_valid = 1'b0;
      bus3.m_req_valid  = '0; bus3.m_req_wen = '0; bus3.m_resp_ready = '0;
      bus3.s_req_ready  = 1'b0; bus3.s_resp_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int base;
      rst_n = 1'b0;
      hold2 = 1'b0;
      acc2  = '0;
      clr_inputs();
      bus2.m_req_addr = '0; bus2.m_req_wdata = '0;
      bus3.m_req_addr = {32'h0300_0003, 32'h0200_0002, 32'h0100_0001};
      bus3.m_req_wdata = '0;

      // Reset holds all outputs low even with live inputs
      #3;
      bus2.m_req_valid = 2'b11; bus2.s_req_ready = 1'b1; bus2.s_resp_valid = 1'b1;
      #1;
      chk_rst();
      do_reset();

      // 1: single read from requester 0, minimum latency
      set_addr2(0, 32'h8000_0000);
      bus2.s_req_ready = 1'b1; bus2.s_resp_valid = 1'b1; bus2.m_resp_ready = 2'b11;
      bus2.m_req_valid = 2'b01;
      exp_g2.push_back(0); push_rsp(0, 32'h8000_0000);
      smp(); chk("t1_c1_sreqv", 32'(bus2.s_req_valid), 0); chk("t1_c1_busy", 32'(bus2.busy), 0); adv();
      smp(); chk("t1_c2_sreqv", 32'(bus2.s_req_valid), 1);
             chk("t1_c2_addr", bus2.s_req_addr, 32'h8000_0000);
             chk("t1_c2_mrdy", 32'(bus2.m_req_ready), 32'h1); adv();
      smp(); chk("t1_c3_rvld", 32'(bus2.m_resp_valid), 32'h1);
             chk("t1_c3_rdata", bus2.m_resp_rdata, 32'h0000_1234);
             chk("t1_c3_srdy", 32'(bus2.s_resp_ready), 1); adv();
      smp(); chk("t1_c4_busy", 32'(bus2.busy), 0); adv();

      // 2: both requesters held valid for four transactions
      do_reset();
      set_addr2(0, 32'h1000_0010); set_addr2(1, 32'h2000_0020);
      bus2.s_req_ready = 1'b1; bus2.s_resp_valid = 1'b1; bus2.m_resp_ready = 2'b11;
      hold2 = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_g2.push_back(t % 2);
         push_rsp(t % 2, (t % 2 == 0) ? 32'h1000_0010 : 32'h2000_0020);
      end
      bus2.m_req_valid = 2'b11;
      base = n_gnt2;
      until_gnt2(base + 4, 40);
      bus2.m_req_valid = 2'b00;
      hold2 = 1'b0;
      wait_idle(20);

      // 3: grant held through s_req_ready stall while requester 1 arrives
      set_addr2(0, 32'h3000_0030);
      bus2.s_req_ready = 1'b0;
      bus2.m_req_valid = 2'b01;
      exp_g2.push_back(0); push_rsp(0, 32'h3000_0030);
      exp_g2.push_back(1); push_rsp(1, 32'h4000_0040);
      smp(); adv();
      for (int i = 0; i < 5; i++) begin
         smp();
         chk("t3_gid", 32'(bus2.grant_id), 0);
         chk("t3_addr", bus2.s_req_addr, 32'h3000_0030);
         chk("t3_mrdy", 32'(bus2.m_req_ready), 0);
         adv();
         if (i == 0) begin
            set_addr2(1, 32'h4000_0040);
            bus2.m_req_valid[1] = 1'b1;
         end
      end
      bus2.s_req_ready = 1'b1;
      wait_idle(30);

      // 4: write from requester 1, response stalled by requester
      set_addr2(1, 32'h5000_0050);
      bus2.m_req_wdata[32 +: 32] = 32'hDEAD_BEEF;
      bus2.m_req_wen = 2'b10;
      bus2.m_resp_ready = 2'b01;
      bus2.m_req_valid = 2'b10;
      exp_g2.push_back(1); push_rsp(1, 32'h5000_0050);
      smp(); adv();
      smp(); chk("t4_wen", 32'(bus2.s_req_wen), 1);
             chk("t4_wdata", bus2.s_req_wdata, 32'hDEAD_BEEF);
             chk("t4_gid", 32'(bus2.grant_id), 1); adv();
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t4_rvld", 32'(bus2.m_resp_valid), 32'h2);
         chk("t4_srdy", 32'(bus2.s_resp_ready), 0);
         chk("t4_busy", 32'(bus2.busy), 1);
         adv();
      end
      bus2.m_resp_ready = 2'b11;
      bus2.m_req_wen = 2'b00;
      wait_idle(10);

      // 5: completed grant to 0, then async reset mid-RESP on another grant to 0
      set_addr2(0, 32'h6000_0060);
      bus2.m_req_valid = 2'b01;
      exp_g2.push_back(0); push_rsp(0, 32'h6000_0060);
      wait_idle(10);
      set_addr2(0, 32'h7000_0070);
      bus2.s_resp_valid = 1'b0;
      bus2.m_req_valid = 2'b01;
      exp_g2.push_back(0);
      smp(); adv();
      smp(); adv();
      smp(); chk("t5_busy", 32'(bus2.busy), 1);
      #1 bus2.s_resp_valid = 1'b1;
      #1 chk("t5_pre_rvld", 32'(bus2.m_resp_valid), 32'h1);
      rst_n = 1'b0;
      #1 chk_rst();
      @(posedge clk);
      @(posedge clk);
      #1;
      set_addr2(0, 32'h7100_0071); set_addr2(1, 32'h7200_0072);
      bus2.m_req_valid = 2'b11;
      exp_g2.push_back(0); push_rsp(0, 32'h7100_0071);
      exp_g2.push_back(1); push_rsp(1, 32'h7200_0072);
      rst_n = 1'b1;
      smp(); chk("t5_post_rvld", 32'(bus2.m_resp_valid), 0);
             chk("t5_post_srdy", 32'(bus2.s_resp_ready), 0); adv();
      wait_idle(20);

      // 6: three requesters, full rotation then requester 1 absent
      do_reset();
      bus3.s_req_ready = 1'b1; bus3.s_resp_valid = 1'b1; bus3.m_resp_ready = 3'b111;
      exp_g3.push_back(0); exp_g3.push_back(1); exp_g3.push_back(2); exp_g3.push_back(0);
      bus3.m_req_valid = 3'b111;
      base = n_gnt3;
      until_gnt3(base + 4, 40);
      bus3.m_req_valid = 3'b000;
      wait_idle(20);
      do_reset();
      bus3.s_req_ready = 1'b1; bus3.s_resp_valid = 1'b1; bus3.m_resp_ready = 3'b111;
      exp_g3.push_back(0); exp_g3.push_back(2); exp_g3.push_back(0); exp_g3.push_back(2);
      bus3.m_req_valid = 3'b101;
      base = n_gnt3;
      until_gnt3(base + 4, 40);
      bus3.m_req_valid = 3'b000;
      wait_idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
